crc16_frame_ctrl: RTL

- Frame-level sequencer for the bit-serial CRC16-MODBUS engine: init 0xFFFF, polynomial 0xA001, 8 cycles per byte.
- Accepts a byte stream with valid/ready/last and feeds each byte to the engine.
- Forwards bytes to a downstream byte sink.
- GEN mode: appends the CRC, low byte first. CHECK mode: verifies the 0x0000 residue.
- Sits between the UART/LoRa packet buffer and the CRC engine; owns every engine control pin.

---
 rtl/crc16_frame_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/crc16_frame_ctrl.sv
// Frame sequencer for a bit-serial CRC16-MODBUS engine (init 0xFFFF, poly 0xA001).
// Streams input bytes into the engine and on to a byte sink. GEN mode appends the
// CRC low byte first; CHECK mode expects the CRC bytes inside the frame and tests
// for a zero residue. This block owns every engine control pin.
module crc16_frame_ctrl #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        eng_init,
  output logic [7:0]  eng_data,
  output logic        eng_data_valid,
  input  logic        eng_busy,
  input  logic [15:0] eng_crc,
  output logic        done,
  output logic        crc_ok,
  output logic        len_err,
  output logic [15:0] crc_value,
  output logic        active
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_ACCEPT = 4'd2;
  localparam logic [3:0] S_FEED   = 4'd3;
  localparam logic [3:0] S_WAIT   = 4'd4;
  localparam logic [3:0] S_CRC_LO = 4'd5;
  localparam logic [3:0] S_CRC_HI = 4'd6;
  localparam logic [3:0] S_DRAIN  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MIN_CHECK = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  logic [3:0]       state;
  logic             mode_reg;   // 1 = CHECK
  logic             last_reg;   // byte being fed carried in_last
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             in_hs;

  // Input is taken only when the single-entry output register is free, or while discarding.
  assign in_ready  = ((state == S_ACCEPT) && !out_valid) || (state == S_DRAIN);
  assign in_hs     = in_valid && in_ready;
  // Byte counter saturates instead of wrapping so an over-long frame stays over-long.
  assign count_inc = (count == CNT_SAT) ? count : count + CNT_ONE;

  // Frame FSM plus all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      mode_reg       <= 1'b0;
      last_reg       <= 1'b0;
      count          <= '0;
      out_data       <= 8'h00;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      eng_init       <= 1'b0;
      eng_data       <= 8'h00;
      eng_data_valid <= 1'b0;
      done           <= 1'b0;
      crc_ok         <= 1'b0;
      len_err        <= 1'b0;
      crc_value      <= 16'h0000;
      active         <= 1'b0;
    end else begin
      eng_init       <= 1'b0;
      eng_data_valid <= 1'b0;
      done           <= 1'b0;
      // Sink took the byte; every load below requires out_valid=0, so no conflict.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (abort && (state != S_IDLE)) begin
        // Abandon the frame and reset the engine; result flags stay as they were.
        state     <= S_IDLE;
        eng_init  <= 1'b1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        active    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state    <= S_INIT;
              mode_reg <= mode;
              crc_ok   <= 1'b0;
              len_err  <= 1'b0;
              count    <= '0;
              eng_init <= 1'b1;
              active   <= 1'b1;
            end
          end
          S_INIT: state <= S_ACCEPT;
          S_ACCEPT: begin
            if (in_hs) begin
              count <= count_inc;
              if (count_inc > MAX_CNT) begin
                // Over-length byte is neither forwarded nor fed.
                len_err <= 1'b1;
                state   <= in_last ? S_DONE : S_DRAIN;
              end else begin
                eng_data       <= in_data;
                eng_data_valid <= 1'b1;
                out_data       <= in_data;
                out_valid      <= 1'b1;
                out_last       <= in_last && mode_reg;
                last_reg       <= in_last;
                state          <= S_FEED;
              end
            end
          end
          S_FEED: state <= S_WAIT;
          S_WAIT: begin
            if (!eng_busy) begin
              if (!last_reg)     state <= S_ACCEPT;
              else if (mode_reg) state <= S_DONE;
              else               state <= S_CRC_LO;
            end
          end
          S_CRC_LO: begin
            if (!out_valid) begin
              out_data  <= eng_crc[7:0];
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              state     <= S_CRC_HI;
            end
          end
          S_CRC_HI: begin
            if (!out_valid) begin
              out_data  <= eng_crc[15:8];
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DRAIN: begin
            if (in_hs && in_last) state <= S_DONE;
          end
          S_DONE: begin
            if (!out_valid) begin
              done      <= 1'b1;
              crc_value <= eng_crc;
              active    <= 1'b0;
              state     <= S_IDLE;
              if (mode_reg && (count < MIN_CHECK)) begin
                // A CHECK frame shorter than a CRC plus one byte cannot be valid.
                len_err <= 1'b1;
                crc_ok  <= 1'b0;
              end else begin
                crc_ok <= mode_reg && !len_err && (eng_crc == 16'h0000);
              end
            end
          end
          default: begin
            state  <= S_IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
